// File: rtl/comparator_seq_ctrl.sv
// rtl/comparator_seq_ctrl.sv - MSB-first bit-serial sequencer for a shared 1-bit equality cell (option: EARLY_EXIT_EN)
module comparator_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_word,
    input  logic [WIDTH-1:0] b_word,
    output logic             cell_a,
    output logic             cell_b,
    input  logic             cell_out,
    output logic [IDX_W-1:0] bit_idx,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             hit, gt_q;
    logic             hit_nxt, gtq_nxt, accept, mismatch;

    // The cell sees the shift-register MSBs directly, so its inputs are glitch-free flop outputs.
    assign cell_a   = a_sh[WIDTH-1];
    assign cell_b   = b_sh[WIDTH-1];
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign mismatch = ~cell_out & ~hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        hit_nxt   = hit;
        gtq_nxt   = gt_q;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (mismatch) begin
                    hit_nxt = 1'b1;
                    gtq_nxt = cell_a;
                end
                if (bit_idx == '0) state_nxt = DONE;
`ifdef EARLY_EXIT_EN
                if (mismatch) state_nxt = DONE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            bit_idx <= '0;
            hit     <= 1'b0;
            gt_q    <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
        end else if (accept) begin
            a_sh    <= a_word;
            b_sh    <= b_word;
            bit_idx <= IDX_W'(WIDTH - 1);
            hit     <= 1'b0;
            gt_q    <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
        end else if (state == RUN) begin
            a_sh <= {a_sh[WIDTH-2:0], 1'b0};
            b_sh <= {b_sh[WIDTH-2:0], 1'b0};
            hit  <= hit_nxt;
            gt_q <= gtq_nxt;
            if (bit_idx != '0) bit_idx <= bit_idx - IDX_W'(1);
            // Flags are latched on the way into DONE so they include this cycle's compare.
            if (state_nxt == DONE) begin
                eq <= ~hit_nxt;
                gt <= hit_nxt & gtq_nxt;
                lt <= hit_nxt & ~gtq_nxt;
            end
        end
    end

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// tb/tb_comparator_seq_ctrl.sv - directed table-driven bench for comparator_seq_ctrl
module tb_comparator_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a_word = '0;
    logic [WIDTH-1:0] b_word = '0;
    logic             cell_a, cell_b, cell_out;
    logic [IDX_W-1:0] bit_idx;
    logic             busy, done, eq, gt, lt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             e_eq;
        logic             e_gt;
        logic             e_lt;
    } vec_t;

    vec_t vecs[8];

    comparator_seq_ctrl #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_word(a_word), .b_word(b_word),
        .cell_a(cell_a), .cell_b(cell_b), .cell_out(cell_out), .bit_idx(bit_idx),
        .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
    );

    assign cell_out = ~(cell_a ^ cell_b);

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef EARLY_EXIT_EN
        for (int i = WIDTH - 1; i >= 0; i--)
            if (a[i] != b[i]) return (WIDTH - 1 - i) + 2;
`endif
        return WIDTH + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start  = 1'b1;
        a_word = a;
        b_word = b;
        step();
        start = 1'b0;
    endtask

    // Called in cycle 1 after the accepting edge; returns during the DONE cycle.
    task automatic watch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic e_eq, input logic e_gt, input logic e_lt,
                         input bit inject);
        int lat;
        bit seen;
        int idx;
        lat  = exp_lat(a, b);
        seen = 0;
        for (int c = 1; c <= 20; c++) begin
            if (inject) begin
                start  = (c >= 3 && c <= 5);
                a_word = 8'h33;
                b_word = 8'h33;
                #1;
            end
            if (done) begin
                chk("done_cycle", c, lat);
                chk("busy_in_done", busy, 0);
                chk("eq", eq, e_eq);
                chk("gt", gt, e_gt);
                chk("lt", lt, e_lt);
                seen = 1;
                break;
            end
            idx = WIDTH - c;
            chk("busy_run", busy, 1);
            chk("bit_idx", bit_idx, idx);
            chk("cell_a", cell_a, a[idx]);
            chk("cell_b", cell_b, b[idx]);
            chk("flags_clear_run", {eq, gt, lt}, 0);
            step();
        end
        if (!seen) chk("done_timeout", 0, 1);
        if (inject) start = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_outs"}, {busy, done, eq, gt, lt, cell_a, cell_b}, 0);
        chk({tag, "_idx"}, bit_idx, 0);
    endtask

    initial begin
        vecs[0] = '{8'h5A, 8'h5A, 1, 0, 0};
        vecs[1] = '{8'h80, 8'h7F, 0, 1, 0};
        vecs[2] = '{8'h01, 8'h02, 0, 0, 1};
        vecs[3] = '{8'hFF, 8'hFF, 1, 0, 0};
        vecs[4] = '{8'h00, 8'h01, 0, 0, 1};
        vecs[5] = '{8'hC3, 8'hC2, 0, 1, 0};
        vecs[6] = '{8'hFE, 8'hFF, 0, 0, 1};
        vecs[7] = '{8'h00, 8'h00, 1, 0, 0};

        #2;
        chk_reset_outputs("reset");
        step();
        rst_n = 1'b1;
        step();
        chk_reset_outputs("idle");

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b);
            watch(vecs[i].a, vecs[i].b, vecs[i].e_eq, vecs[i].e_gt, vecs[i].e_lt, 0);
            step();
            chk("done_pulse_width", done, 0);
            chk("flags_held", {eq, gt, lt}, {vecs[i].e_eq, vecs[i].e_gt, vecs[i].e_lt});
        end

        // Start while busy is ignored; start during DONE is accepted back-to-back.
        issue(8'h00, 8'hFF);
        watch(8'h00, 8'hFF, 0, 0, 1, 1);
        issue(8'h33, 8'h33);
        watch(8'h33, 8'h33, 1, 0, 0, 0);
        step();

        // Reset mid-RUN aborts with no done pulse.
        issue(8'hA5, 8'h5A);
        step(); step(); step();
        chk("busy_before_abort", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        for (int c = 0; c < 12; c++) begin
            if (c == 3) rst_n = 1'b1;
            step();
            chk("no_done_after_abort", done, 0);
        end
        issue(8'h12, 8'h34);
        watch(8'h12, 8'h34, 0, 0, 1, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
